// File: rtl/des_round_sequencer.sv
`timescale 1ns/1ps
// Iterative DES Feistel round controller: one E/XOR/S-box/P round per cycle
// through an external S-box wrapper and key schedule, returning R16||L16.
module des_round_sequencer #(
  parameter int unsigned ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        decrypt,
  input  logic [63:0] data_in,
  output logic [3:0]  round_idx,
  input  logic [47:0] subkey,
  output logic [47:0] sbox_in,
  input  logic [31:0] sbox_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  localparam int unsigned P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // E table groups g take R positions 4g..4g+5 (1-based, wrapping 0->32, 33->1)
  function automatic logic [47:0] e_expand(input logic [31:0] r);
    logic [47:0] e;
    int unsigned pos;
    e = '0;
    for (int unsigned j = 0; j < 48; j++) begin
      pos = ((4 * (j / 6)) + (j % 6) + 31) % 32 + 1;
      e[6'(47 - j)] = r[5'(32 - pos)];
    end
    return e;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] s);
    logic [31:0] p;
    p = '0;
    for (int unsigned j = 0; j < 32; j++) begin
      p[5'(31 - j)] = s[5'(32 - P_TAB[j])];
    end
    return p;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] l_q, r_q;
  logic [3:0]  cnt_q;
  logic        mode_q;
  logic [31:0] f;
  logic [47:0] e_r;

  assign e_r = e_expand(r_q);
  assign f   = p_perm(sbox_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      l_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      data_out <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            l_q    <= data_in[63:32];
            r_q    <= data_in[31:0];
            cnt_q  <= '0;
            mode_q <= decrypt;
          end
        end
        ROUND: begin
          // Last round skips the swap so the result is already R16||L16.
          if (cnt_q == LAST) begin
            data_out <= {l_q ^ f, r_q};
          end else begin
            l_q   <= r_q;
            r_q   <= l_q ^ f;
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    round_idx = '0;
    sbox_in   = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ROUND;
      end
      ROUND: begin
        busy      = 1'b1;
        round_idx = mode_q ? (LAST - cnt_q) : cnt_q;
        sbox_in   = e_r ^ subkey;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_des_round_sequencer.sv
`timescale 1ns/1ps
// Directed bench for des_round_sequencer with a DES key-schedule and S-box
// model on the subkey/sbox ports, using the classic 133457799BBCDFF1 vector.
module tb_des_round_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        decrypt = 1'b0;
  logic [63:0] data_in = '0;
  logic [3:0]  round_idx;
  logic [47:0] subkey;
  logic [47:0] sbox_in;
  logic [31:0] sbox_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] data_out;
  logic        busy;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] KEY     = 64'h133457799BBCDFF1;
  localparam logic [63:0] ENC_IN  = 64'hCC00CCFF_F0AAF0AA;
  localparam logic [63:0] ENC_OUT = 64'h0A4CD995_43423234;
  localparam logic [63:0] DEC_IN  = 64'h0A4CD995_43423234;
  localparam logic [63:0] DEC_OUT = 64'hCC00CCFF_F0AAF0AA;

  int pc1 [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
                   10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                   63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                   14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  int pc2 [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,
                   23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                   41,52,31,37,47,55,30,40,51,45,33,48,
                   44,49,39,56,34,53,46,42,50,36,29,32};
  int shifts [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  int sbt [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
  };

  logic [47:0] ks [16];

  function automatic logic [31:0] sbox_f(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  six;
    int          idx;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      six = x[47 - 6 * i -: 6];
      idx = int'({six[5], six[0]}) * 16 + int'(six[4:1]);
      y[31 - 4 * i -: 4] = 4'(sbt[i][idx]);
    end
    return y;
  endfunction

  task automatic build_ks(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - pc1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < shifts[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) k[47 - j] = cd[56 - pc2[j]];
      ks[r] = k;
    end
  endtask

  always_comb subkey = ks[round_idx];
  always_comb sbox_out = sbox_f(sbox_in);

  always #5 clk = ~clk;

  des_round_sequencer #(.ROUNDS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .decrypt   (decrypt),
    .data_in   (data_in),
    .round_idx (round_idx),
    .subkey    (subkey),
    .sbox_in   (sbox_in),
    .sbox_out  (sbox_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [63:0] din, input logic dec);
    data_in  = din;
    decrypt  = dec;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (data_out !== 64'h0) begin errors++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
    rst = 1'b0;
  endtask

  task automatic test_encrypt;
    int n;
    out_ready = 1'b1;
    accept(ENC_IN, 1'b0);
    checks++; if (round_idx !== 4'd0) begin errors++; $display("FAIL enc_r1_idx got=%0d exp=0", round_idx); end
    checks++; if (subkey !== 48'h1B02EFFC7072) begin errors++; $display("FAIL enc_r1_subkey got=%h exp=1b02effc7072", subkey); end
    checks++; if (sbox_in !== 48'h6117BA866527) begin errors++; $display("FAIL enc_r1_sbox_in got=%h exp=6117ba866527", sbox_in); end
    checks++; if (sbox_out !== 32'h5C82B597) begin errors++; $display("FAIL enc_r1_sbox_out got=%h exp=5c82b597", sbox_out); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL enc_round_flags got in_ready=%b busy=%b exp 0/1", in_ready, busy); end
    tick();
    checks++; if (dut.r_q !== 32'hEF4A6544) begin errors++; $display("FAIL enc_r1_R got=%h exp=ef4a6544", dut.r_q); end
    checks++; if (dut.l_q !== 32'hF0AAF0AA) begin errors++; $display("FAIL enc_r1_L got=%h exp=f0aaf0aa", dut.l_q); end
    checks++; if (round_idx !== 4'd1) begin errors++; $display("FAIL enc_r2_idx got=%0d exp=1", round_idx); end
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL enc_latency got=%0d exp=16", n); end
    checks++; if (data_out !== ENC_OUT) begin errors++; $display("FAIL enc_data_out got=%h exp=%h", data_out, ENC_OUT); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL enc_done_in_ready got=%b exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL enc_post_hs got out_valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, busy);
    end
    checks++; if (data_out !== ENC_OUT) begin errors++; $display("FAIL enc_hold got=%h exp=%h", data_out, ENC_OUT); end
  endtask

  task automatic test_decrypt;
    int n;
    accept(DEC_IN, 1'b1);
    decrypt = 1'b0;
    checks++; if (subkey !== 48'hCB3D8B0E17F5) begin errors++; $display("FAIL dec_r1_subkey got=%h exp=cb3d8b0e17f5", subkey); end
    n = 0;
    while (!out_valid && n < 40) begin
      checks++; if (round_idx !== 4'(15 - n)) begin errors++; $display("FAIL dec_round_idx step=%0d got=%0d exp=%0d", n, round_idx, 15 - n); end
      tick();
      n++;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL dec_latency got=%0d exp=16", n); end
    checks++; if (data_out !== DEC_OUT) begin errors++; $display("FAIL dec_data_out got=%h exp=%h", data_out, DEC_OUT); end
    tick();
  endtask

  task automatic test_backpressure;
    int n;
    out_ready = 1'b0;
    accept(ENC_IN, 1'b0);
    wait_valid(n);
    checks++; if (n !== 16) begin errors++; $display("FAIL bp_latency got=%0d exp=16", n); end
    in_valid = 1'b1;
    data_in  = DEC_IN;
    decrypt  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_flags cyc=%0d got out_valid=%b in_ready=%b exp 1/0", i, out_valid, in_ready);
      end
      checks++; if (data_out !== ENC_OUT) begin errors++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=%h", i, data_out, ENC_OUT); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got out_valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    accept(DEC_IN, 1'b1);
    repeat (6) tick();
    checks++; if (round_idx !== 4'd9) begin errors++; $display("FAIL rstmid_idx got=%0d exp=9", round_idx); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_flags got out_valid=%b busy=%b in_ready=%b exp 0/0/1", out_valid, busy, in_ready);
    end
    checks++; if (data_out !== 64'h0) begin errors++; $display("FAIL rstmid_data got=%h exp=0", data_out); end
    accept(ENC_IN, 1'b0);
    wait_valid(n);
    checks++; if (n !== 16) begin errors++; $display("FAIL rstmid_latency got=%0d exp=16", n); end
    checks++; if (data_out !== ENC_OUT) begin errors++; $display("FAIL rstmid_data_out got=%h exp=%h", data_out, ENC_OUT); end
    tick();
  endtask

  task automatic test_busy_input;
    int n;
    accept(ENC_IN, 1'b0);
    n = 0;
    while (!out_valid && n < 40) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready step=%0d got=%b exp=0", n, in_ready); end
      in_valid = 1'($urandom_range(0, 1));
      data_in  = {$urandom, $urandom};
      decrypt  = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    in_valid = 1'b0;
    checks++; if (n !== 16) begin errors++; $display("FAIL busy_latency got=%0d exp=16", n); end
    checks++; if (data_out !== ENC_OUT) begin errors++; $display("FAIL busy_data_out got=%h exp=%h", data_out, ENC_OUT); end
    tick();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL busy_extra_accept got busy=%b in_ready=%b out_valid=%b exp 0/1/0", busy, in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    data_in  = ENC_IN;
    decrypt  = 1'b0;
    in_valid = 1'b1;
    tick();
    wait_valid(n);
    checks++; if (n !== 16) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=16", n); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_in_ready got=%b exp=0", in_ready); end
    n = 0;
    do begin
      tick();
      n++;
      if (busy) in_valid = 1'b0;
    end while (!out_valid && n < 60);
    in_valid = 1'b0;
    checks++; if (n !== 18) begin errors++; $display("FAIL b2b_period got=%0d exp=18", n); end
    checks++; if (data_out !== ENC_OUT) begin errors++; $display("FAIL b2b_data_out got=%h exp=%h", data_out, ENC_OUT); end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_ks(KEY);
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_reset_mid();
    test_busy_input();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
